alu_result_buffer: RTL and testbench

Execute-to-writeback stage that sits directly downstream of the 32-bit ALU. It captures each ALU result together with its Z/N flags and destination tag into a 2-entry skid buffer with a valid/ready handshake. It maintains the architectural Z/N flag register and resolves conditional branches against it. Writeback and PC-select logic consume its output.

---
 rtl/alu_result_buffer_if.sv | 49 ++++
 rtl/alu_result_buffer.sv | 147 ++++++++++++++
 tb/tb_alu_result_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_buffer_if.sv
// rtl/alu_result_buffer_if.sv - ALU result / writeback handshake bundle
//
// Groups the upstream (in_*) and downstream (out_*) handshakes of the
// execute-to-writeback buffer, plus the architectural flag outputs.
//   slave  : the buffer side (consumes in_*, out_ready; drives the rest)
//   master : the environment side (ALU upstream + writeback downstream)
interface alu_result_buffer_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) ();
    // upstream: ALU -> buffer
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_z;
    logic              in_n;
    logic              in_setflags;
    logic [1:0]        in_br;
    logic [RD_W-1:0]   in_rd;
    logic              in_wr_en;

    // downstream: buffer -> writeback / PC select
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_wr_en;
    logic              out_taken;

    // architectural flag register
    logic              flag_z;
    logic              flag_n;

    modport slave (
        input  in_valid, in_result, in_z, in_n, in_setflags, in_br, in_rd, in_wr_en,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_rd, out_wr_en, out_taken,
        output flag_z, flag_n
    );

    modport master (
        output in_valid, in_result, in_z, in_n, in_setflags, in_br, in_rd, in_wr_en,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_rd, out_wr_en, out_taken,
        input  flag_z, flag_n
    );
endinterface

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - execute-to-writeback 2-entry skid buffer with flag register and branch resolve
//
// Captures ALU results into a 2-deep FIFO, keeps the Z/N flag register and
// resolves conditional branches against the flags held before each push.
// Ports:
//   clk   - single clock, rising edge
//   rst   - synchronous active-high reset (priority over flush)
//   flush - synchronous flush, drops all buffered entries and any same-cycle push
//   bus   - alu_result_buffer_if.slave (in_* / out_* handshakes, flag_z/flag_n)
module alu_result_buffer #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    alu_result_buffer_if.slave   bus
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              wr_en;
        logic              taken;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t  state_q;
    logic    head_q;
    entry_t  slot_q [2];
    logic    flag_z_q;
    logic    flag_n_q;
    logic    in_ready_q;
    logic    out_valid_q;

    logic    push;
    logic    pop;
    logic    tail;
    logic    taken_d;
    entry_t  entry_d;

    assign push = bus.in_valid & in_ready_q;
    assign pop  = out_valid_q & bus.out_ready;

    // Slot the next push lands in: head when empty, the other slot when one
    // entry is held. Never used in FULL because in_ready is low there.
    assign tail = head_q ^ (state_q == ONE);

    // Branch decision uses the flags as they stand before this push, so an
    // instruction that both sets flags and branches sees the old values.
    always_comb begin
        taken_d = 1'b0;
        case (bus.in_br)
            2'b01:   taken_d = flag_z_q;
            2'b10:   taken_d = flag_n_q;
            2'b11:   taken_d = 1'b1;
            default: taken_d = 1'b0;
        endcase
    end

    // A taken branch carries its target in result and must not write the
    // register file.
    always_comb begin
        entry_d        = '0;
        entry_d.result = bus.in_result;
        entry_d.rd     = bus.in_rd;
        entry_d.wr_en  = bus.in_wr_en & ~taken_d;
        entry_d.taken  = taken_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= 1'b0;
            slot_q[0]   <= '0;
            slot_q[1]   <= '0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            // Payload and head are left as they are; with count back at zero
            // nothing stale is ever presented as valid.
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                slot_q[tail] <= entry_d;
                if (bus.in_setflags) begin
                    flag_z_q <= bus.in_z;
                    flag_n_q <= bus.in_n;
                end
            end

            // Every pop advances head, so head always names the oldest entry.
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (pop) begin
                        head_q <= ~head_q;
                    end
                    if (push && !pop) begin
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop && !push) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_q    <= ONE;
                        head_q     <= ~head_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come only from registered state; no in_* to out_* path.
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = slot_q[head_q].result;
    assign bus.out_rd     = slot_q[head_q].rd;
    assign bus.out_wr_en  = slot_q[head_q].wr_en;
    assign bus.out_taken  = slot_q[head_q].taken;
    assign bus.flag_z     = flag_z_q;
    assign bus.flag_n     = flag_n_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - self-checking bench for alu_result_buffer
module tb_alu_result_buffer;

    logic clk;
    logic rst;
    logic flush;

    alu_result_buffer_if #(.DATA_W(32), .RD_W(5)) bus ();

    alu_result_buffer #(.DATA_W(32), .RD_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wr_en;
        logic        taken;
    } ent_t;

    ent_t        mq[$];
    bit          mz;
    bit          mn;
    logic [31:0] popped[$];
    int          n_chk;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a queue of at most two entries and two flag bits.
    task automatic model_edge();
        bit   acc;
        bit   pp;
        bit   tk;
        ent_t e;
        if (rst) begin
            mq.delete();
            mz = 0;
            mn = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            acc = bus.in_valid && (mq.size() < 2);
            pp  = (mq.size() > 0) && bus.out_ready;
            tk  = (bus.in_br == 2'b11) || (bus.in_br == 2'b01 && mz) || (bus.in_br == 2'b10 && mn);
            e.result = bus.in_result;
            e.rd     = bus.in_rd;
            e.wr_en  = tk ? 1'b0 : bus.in_wr_en;
            e.taken  = tk;
            if (pp) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                if (bus.in_setflags) begin
                    mz = bus.in_z;
                    mn = bus.in_n;
                end
            end
        end
    endtask

    task automatic check_state();
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() < 2});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
        chk("flag_z", {31'd0, bus.flag_z}, {31'd0, mz});
        chk("flag_n", {31'd0, bus.flag_n}, {31'd0, mn});
        if (mq.size() != 0) begin
            chk("out_result", bus.out_result, mq[0].result);
            chk("out_rd", {27'd0, bus.out_rd}, {27'd0, mq[0].rd});
            chk("out_wr_en", {31'd0, bus.out_wr_en}, {31'd0, mq[0].wr_en});
            chk("out_taken", {31'd0, bus.out_taken}, {31'd0, mq[0].taken});
        end
    endtask

    task automatic tick();
        if (bus.out_valid && bus.out_ready) popped.push_back(bus.out_result);
        model_edge();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic set_in(input bit v, input logic [31:0] r, input bit z, input bit n,
                          input bit sf, input logic [1:0] br, input logic [4:0] rd, input bit wr);
        bus.in_valid    = v;
        bus.in_result   = r;
        bus.in_z        = z;
        bus.in_n        = n;
        bus.in_setflags = sf;
        bus.in_br       = br;
        bus.in_rd       = rd;
        bus.in_wr_en    = wr;
    endtask

    initial begin
        bit hold;
        n_chk  = 0;
        n_fail = 0;
        mz     = 0;
        mn     = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        bus.out_ready = 1'b0;
        set_in(0, 32'h0, 0, 0, 0, 2'b00, 5'd0, 0);

        // reset state
        tick();
        tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
        chk("rst_out_taken", {31'd0, bus.out_taken}, 32'd0);
        rst = 1'b0;

        // plain push, one cycle latency
        set_in(1, 32'h5, 0, 0, 0, 2'b00, 5'd3, 1);
        tick();
        chk("t1_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_result", bus.out_result, 32'd5);
        chk("t1_rd", {27'd0, bus.out_rd}, 32'd3);
        chk("t1_wr_en", {31'd0, bus.out_wr_en}, 32'd1);
        chk("t1_flags", {30'd0, bus.flag_z, bus.flag_n}, 32'd0);
        bus.out_ready = 1'b1;
        set_in(0, 32'h0, 0, 0, 0, 2'b00, 5'd0, 0);
        tick();

        // branch-if-Z after a flag-setting push
        set_in(1, 32'hAA, 1, 0, 1, 2'b00, 5'd1, 1);
        tick();
        set_in(1, 32'h100, 0, 0, 0, 2'b01, 5'd2, 1);
        tick();
        chk("bz_taken", {31'd0, bus.out_taken}, 32'd1);
        chk("bz_wr_en", {31'd0, bus.out_wr_en}, 32'd0);
        chk("bz_result", bus.out_result, 32'h100);
        set_in(1, 32'hBB, 0, 0, 1, 2'b00, 5'd1, 1);
        tick();
        set_in(1, 32'h200, 0, 0, 0, 2'b01, 5'd2, 1);
        tick();
        chk("bnz_taken", {31'd0, bus.out_taken}, 32'd0);
        chk("bnz_wr_en", {31'd0, bus.out_wr_en}, 32'd1);

        // set N and branch-if-N in the same instruction tests the old N
        set_in(1, 32'h300, 0, 1, 1, 2'b10, 5'd4, 1);
        tick();
        chk("sfbr_taken", {31'd0, bus.out_taken}, 32'd0);
        chk("sfbr_flag_n", {31'd0, bus.flag_n}, 32'd1);
        set_in(0, 32'h0, 0, 0, 0, 2'b00, 5'd0, 0);
        tick();
        tick();

        // back-pressure: 1,2,3 with out_ready low
        bus.out_ready = 1'b0;
        popped.delete();
        set_in(1, 32'd1, 0, 0, 0, 2'b00, 5'd5, 1);
        tick();
        set_in(1, 32'd2, 0, 0, 0, 2'b00, 5'd5, 1);
        tick();
        chk("bp_in_ready_drop", {31'd0, bus.in_ready}, 32'd0);
        set_in(1, 32'd3, 0, 0, 0, 2'b00, 5'd5, 1);
        tick();
        chk("bp_in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_head_hold", bus.out_result, 32'd1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        set_in(0, 32'h0, 0, 0, 0, 2'b00, 5'd0, 0);
        tick();
        tick();
        chk("bp_pop_count", popped.size(), 32'd3);
        for (int i = 0; i < popped.size() && i < 3; i++)
            chk("bp_order", popped[i], i + 1);

        // flush with two buffered entries and a same-cycle flag-setting push
        bus.out_ready = 1'b0;
        set_in(1, 32'h11, 0, 0, 0, 2'b00, 5'd6, 1);
        tick();
        set_in(1, 32'h22, 0, 0, 0, 2'b00, 5'd7, 1);
        tick();
        flush = 1'b1;
        set_in(1, 32'h33, 1, 0, 1, 2'b11, 5'd8, 1);
        tick();
        flush = 1'b0;
        chk("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("fl_flag_z", {31'd0, bus.flag_z}, 32'd0);
        chk("fl_flag_n", {31'd0, bus.flag_n}, 32'd1);

        // 8 back-to-back pushes, then reset mid-stream
        bus.out_ready = 1'b1;
        popped.delete();
        for (int i = 0; i < 8; i++) begin
            set_in(1, 32'h1000 + i, 1, 1, (i == 3), 2'b00, i[4:0], 1);
            chk("st_in_ready", {31'd0, bus.in_ready}, 32'd1);
            tick();
        end
        set_in(1, 32'h2000, 0, 0, 0, 2'b00, 5'd9, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("st_pop_count", popped.size(), 32'd8);
        for (int i = 0; i < popped.size() && i < 8; i++)
            chk("st_order", popped[i], 32'h1000 + i);
        chk("mr_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mr_flags", {30'd0, bus.flag_z, bus.flag_n}, 32'd0);

        // randomized traffic; held inputs stay stable until accepted
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                set_in($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 1), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                       $urandom_range(0, 1));
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 49) == 0;
            rst   = $urandom_range(0, 199) == 0;
            hold  = bus.in_valid && (mq.size() == 2) && !flush && !rst;
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
